window_scan_scheduler: RTL and testbench
========================================

# window_scan_scheduler

Sequences the sliding-window face classifier across the camera frame. Each window origin is held for one full video frame; the scheduler then collects the classifier verdict, records hits and steps the origin across a fixed grid. It drives the bounding-box overlay flag (`oIS_BOUND`) consumed by the VGA decorator, and sits between the VGA position counters and the linear classifier control unit, all on the VGA pixel clock.

## Interface
- `FRAME_W`, default 640: active frame width in pixels.
- `FRAME_H`, default 480: active frame height in pixels.
- `WIN_W`, default 64: window width in pixels.
- `WIN_H`, default 64: window height in pixels.
- `STEP`, default 32: grid stride in pixels, applied in both X and Y.
- `TIMEOUT`, default 1024: maximum number of cycles to wait for a classifier verdict.
---
- `iCLK` in 1: pixel clock, the only clock.
- `iRST_N` in 1: reset, synchronous and active-low.
- `iSTART` in 1: one-cycle pulse that starts a scan.
- `iCONTINUOUS` in 1: when 1, a finished scan restarts automatically.
- `iX_POS` in 13: current pixel X position.
- `iY_POS` in 13: current pixel Y position.
- `iFRAME_END` in 1: one-cycle pulse after the last active pixel of a frame.
- `iRESULT_VALID` in 1: classifier verdict strobe.
- `iRESULT` in 1: classifier verdict (1 = face).
- `oWIN_X` out 13: current window origin X.
- `oWIN_Y` out 13: current window origin Y.
- `oIS_BOUND` out 1: current pixel lies on the window perimeter (registered).
- `oBUSY` out 1: a scan is in progress.
- `oSCAN_DONE` out 1: one-cycle pulse when a scan completes.
- `oHIT_COUNT` out 8: hits in the current or last scan; saturates at 255.
- `oHIT_X` out 13: origin X of the most recent hit.
- `oHIT_Y` out 13: origin Y of the most recent hit.
- `oTIMEOUT` out 1: sticky flag, set when any verdict times out; cleared by start or reset.

## Operation
**States:** IDLE, ARM, MEASURE, RESULT, ADVANCE.
- **IDLE:** `oBUSY`=0.
  - On `iSTART`: set the origin to (0,0), clear `oHIT_COUNT`, `oHIT_X`, `oHIT_Y` and `oTIMEOUT`, then go to ARM.
- **ARM:** wait for `iFRAME_END`, then go to MEASURE. The window is therefore applied from the first pixel of the next frame.
- **MEASURE:** the origin is held for a whole frame. At the next `iFRAME_END`, clear the timeout counter and go to RESULT.
- **RESULT:**
  - On `iRESULT_VALID`: if `iRESULT`=1, increment `oHIT_COUNT` (saturating at 255) and latch `oHIT_X`/`oHIT_Y` from the current origin. Then go to ADVANCE.
  - If the counter reaches `TIMEOUT`-1 with no strobe: set `oTIMEOUT`, count the window as a miss, and go to ADVANCE.
- **ADVANCE:** one cycle.
  - If `oWIN_X`+`STEP`+`WIN_W` ≤ `FRAME_W`: `oWIN_X` += `STEP`.
  - Otherwise: `oWIN_X`=0. Then if `oWIN_Y`+`STEP`+`WIN_H` ≤ `FRAME_H`: `oWIN_Y` += `STEP`.
  - Otherwise the scan is complete: pulse `oSCAN_DONE`. Then, if `iCONTINUOUS`=1, restart as on `iSTART` (origin (0,0), counters cleared, go to ARM); else go to IDLE.
  - If not complete: go to ARM.
- **Arithmetic:** all position sums are computed 14 bits wide, so there is no wrap-around.
- **Window grid** at defaults:
  - X origins 0..576 (19 positions); Y origins 0..416 (14 positions).
  - 266 windows per scan.
- **Perimeter:** `oIS_BOUND`=1 when
  - (`iY_POS`==`oWIN_Y` or `iY_POS`==`oWIN_Y`+`WIN_H`-1) and `oWIN_X` ≤ `iX_POS` ≤ `oWIN_X`+`WIN_W`-1, or
  - (`iX_POS`==`oWIN_X` or `iX_POS`==`oWIN_X`+`WIN_W`-1) and `oWIN_Y` ≤ `iY_POS` ≤ `oWIN_Y`+`WIN_H`-1.
  - Valid in every state except IDLE, where it is 0.
- **Ignored inputs and simultaneous events:**
  - `iSTART` outside IDLE is ignored.
  - `iRESULT_VALID` outside RESULT is ignored.
  - `iFRAME_END` in RESULT or ADVANCE is ignored; ARM then waits for the following frame end.
  - `iRESULT_VALID` in the same cycle as the timeout terminal count: the verdict wins and `oTIMEOUT` is not set.
- **Reset:** `iRST_N`=0 at a clock edge forces IDLE from any state, including mid-scan. All outputs then read 0: origin (0,0), counters 0, all flags 0.

## Timing
- Every output is a flop. `oIS_BOUND` lags `iX_POS`/`iY_POS` by 1 cycle.
- `oWIN_X`/`oWIN_Y` change only on the ADVANCE cycle or on a start. They are stable throughout ARM, MEASURE and RESULT.
- IDLE→ARM takes 1 cycle after `iSTART`. The RESULT→ADVANCE→ARM path takes 2 cycles after the strobe.
- Each window costs 2 frames (ARM + MEASURE) plus the verdict latency.
- `oHIT_COUNT`, `oHIT_X` and `oHIT_Y` update on the cycle after the accepted strobe.
- `oSCAN_DONE` is high for exactly 1 cycle: the cycle after the final ADVANCE.
- `oBUSY`=1 from the cycle after a start until the cycle `oSCAN_DONE` is asserted (inclusive). In continuous mode it stays 1.

## Test plan
- **Reset:** hold `iRST_N`=0 for 3 cycles mid-MEASURE → all outputs 0 on the next cycle, state IDLE; `iSTART` then reaches ARM after 1 cycle.
- **Grid walk:** full scan at defaults with `iRESULT_VALID` 5 cycles after each `iFRAME_END` and `iRESULT`=0.
  - Origins follow (0,0), (32,0) … (576,0), (0,32) … (576,416).
  - Exactly 266 verdicts are consumed; one `oSCAN_DONE` pulse; `oHIT_COUNT`=0.
- **Hits:** `iRESULT`=1 only at windows (64,32) and (128,96) → `oHIT_COUNT`=2, `oHIT_X`=128, `oHIT_Y`=96.
- **Timeout:** withhold the verdict at window (32,0) → `oTIMEOUT`=1 exactly 1024 cycles after `iFRAME_END`, origin advances to (64,0), `oHIT_COUNT` unchanged.
  - Repeat with the strobe arriving on the terminal-count cycle → `oTIMEOUT` stays 0.
- **Perimeter:** origin (32,0) → `oIS_BOUND`=1 one cycle after positions (32,10), (95,10), (50,0), (50,63); 0 after (96,10), (50,64), (31,0).
- **Saturation and continuous mode:** `iRESULT`=1 on every window with `iCONTINUOUS`=1 → `oHIT_COUNT` holds at 255.
  - After `oSCAN_DONE`: the origin returns to (0,0), `oHIT_COUNT`=0 and `oBUSY` stays 1.
  - `iSTART` pulses during the scan have no effect.

Source files
------------

// File: rtl/window_scan_scheduler_if.sv
// ----------------------------------------------------------------------------
// window_scan_scheduler_if
//
// Purpose: bundles every signal between the window scan scheduler and its
// surroundings (VGA position counters, classifier control, VGA decorator).
// Clock and reset stay plain ports on the scheduler itself.
//
// Signals (directions as seen by the scheduler, modport "slave"):
//   iSTART        in   one-cycle scan start pulse
//   iCONTINUOUS   in   restart automatically after a completed scan
//   iX_POS        in   current pixel X position (13 bits)
//   iY_POS        in   current pixel Y position (13 bits)
//   iFRAME_END    in   one-cycle pulse after the last active pixel of a frame
//   iRESULT_VALID in   classifier verdict strobe
//   iRESULT       in   classifier verdict (1 = face)
//   oWIN_X/oWIN_Y out  current window origin
//   oIS_BOUND     out  registered "pixel is on window perimeter" flag
//   oBUSY         out  scan in progress
//   oSCAN_DONE    out  one-cycle scan complete pulse
//   oHIT_COUNT    out  saturating hit count of the current/last scan
//   oHIT_X/oHIT_Y out  origin of the most recent hit
//   oTIMEOUT      out  sticky verdict-timeout flag
//   dbg_state     out  FSM state encoding for observation
//
// Handshake: the verdict path is a strobe with no back-pressure. iRESULT is
// qualified by iRESULT_VALID, which is only accepted while the scheduler is
// waiting for a verdict; strobes at any other time are dropped.
// ----------------------------------------------------------------------------
interface window_scan_scheduler_if;
    logic        iSTART;
    logic        iCONTINUOUS;
    logic [12:0] iX_POS;
    logic [12:0] iY_POS;
    logic        iFRAME_END;
    logic        iRESULT_VALID;
    logic        iRESULT;
    logic [12:0] oWIN_X;
    logic [12:0] oWIN_Y;
    logic        oIS_BOUND;
    logic        oBUSY;
    logic        oSCAN_DONE;
    logic [7:0]  oHIT_COUNT;
    logic [12:0] oHIT_X;
    logic [12:0] oHIT_Y;
    logic        oTIMEOUT;
    logic [2:0]  dbg_state;

    // Environment side: drives stimulus, observes results.
    modport master (
        output iSTART, iCONTINUOUS, iX_POS, iY_POS, iFRAME_END,
               iRESULT_VALID, iRESULT,
        input  oWIN_X, oWIN_Y, oIS_BOUND, oBUSY, oSCAN_DONE, oHIT_COUNT,
               oHIT_X, oHIT_Y, oTIMEOUT, dbg_state
    );

    // Scheduler side.
    modport slave (
        input  iSTART, iCONTINUOUS, iX_POS, iY_POS, iFRAME_END,
               iRESULT_VALID, iRESULT,
        output oWIN_X, oWIN_Y, oIS_BOUND, oBUSY, oSCAN_DONE, oHIT_COUNT,
               oHIT_X, oHIT_Y, oTIMEOUT, dbg_state
    );
endinterface

// File: rtl/window_scan_scheduler.sv
// ----------------------------------------------------------------------------
// window_scan_scheduler
//
// Purpose: steps the sliding-window face classifier across the camera frame.
// Each window origin is held for a full video frame, then the classifier
// verdict is collected, hits are recorded and the origin moves to the next
// grid position (row-major, STEP pixels in X and Y). Also produces the
// registered bounding-box overlay flag for the VGA decorator.
//
// Ports:
//   iCLK    in  pixel clock (only clock)
//   iRST_N  in  synchronous active-low reset
//   bus     window_scan_scheduler_if.slave, see interface header
//
// State sequence: IDLE -> ARM -> MEASURE -> RESULT -> ADVANCE -> ARM ...
//   ARM     waits for a frame end so the window starts on a fresh frame
//   MEASURE holds the window for one whole frame
//   RESULT  waits up to TIMEOUT cycles for the verdict strobe
//   ADVANCE one cycle: move the origin or finish the scan
// ----------------------------------------------------------------------------
module window_scan_scheduler #(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int WIN_W   = 64,
    parameter int WIN_H   = 64,
    parameter int STEP    = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    window_scan_scheduler_if.slave  bus
);

    // All position arithmetic is carried one bit wider than the 13-bit
    // coordinates so sums never wrap.
    localparam logic [13:0] FW14   = 14'(FRAME_W);
    localparam logic [13:0] FH14   = 14'(FRAME_H);
    localparam logic [13:0] WW14   = 14'(WIN_W);
    localparam logic [13:0] WH14   = 14'(WIN_H);
    localparam logic [13:0] STEP14 = 14'(STEP);

    localparam int              CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        MEASURE = 3'd2,
        RESULT  = 3'd3,
        ADVANCE = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [12:0]   win_x;
    logic [12:0]   win_y;
    logic [7:0]    hit_cnt;
    logic [12:0]   hit_x;
    logic [12:0]   hit_y;
    logic          timeout_flag;
    logic          busy;
    logic          scan_done;
    logic          is_bound;
    logic [CW-1:0] to_cnt;

    logic [12:0]   win_x_next;
    logic [12:0]   win_y_next;
    logic [7:0]    hit_cnt_next;
    logic [12:0]   hit_x_next;
    logic [12:0]   hit_y_next;
    logic          timeout_next;
    logic          busy_next;
    logic          scan_done_next;
    logic          is_bound_next;
    logic [CW-1:0] to_cnt_next;

    // ------------------------------------------------------------------
    // Grid stepping sums
    // ------------------------------------------------------------------
    logic [13:0] x_step;
    logic [13:0] y_step;
    logic        x_fits;
    logic        y_fits;

    assign x_step = {1'b0, win_x} + STEP14;
    assign y_step = {1'b0, win_y} + STEP14;
    assign x_fits = (x_step + WW14) <= FW14;
    assign y_fits = (y_step + WH14) <= FH14;

    // ------------------------------------------------------------------
    // Window perimeter test against the current pixel position
    // ------------------------------------------------------------------
    logic [13:0] pix_x;
    logic [13:0] pix_y;
    logic [13:0] left;
    logic [13:0] top;
    logic [13:0] right;
    logic [13:0] bottom;
    logic        in_x_span;
    logic        in_y_span;
    logic        on_row_edge;
    logic        on_col_edge;

    assign pix_x  = {1'b0, bus.iX_POS};
    assign pix_y  = {1'b0, bus.iY_POS};
    assign left   = {1'b0, win_x};
    assign top    = {1'b0, win_y};
    assign right  = left + WW14 - 14'd1;
    assign bottom = top + WH14 - 14'd1;

    assign in_x_span   = (pix_x >= left) && (pix_x <= right);
    assign in_y_span   = (pix_y >= top) && (pix_y <= bottom);
    assign on_row_edge = (pix_y == top) || (pix_y == bottom);
    assign on_col_edge = (pix_x == left) || (pix_x == right);

    // The overlay is suppressed while idle so no stale box is drawn.
    assign is_bound_next = (state != IDLE) &&
                           ((on_row_edge && in_x_span) ||
                            (on_col_edge && in_y_span));

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        win_x_next     = win_x;
        win_y_next     = win_y;
        hit_cnt_next   = hit_cnt;
        hit_x_next     = hit_x;
        hit_y_next     = hit_y;
        timeout_next   = timeout_flag;
        to_cnt_next    = to_cnt;
        scan_done_next = 1'b0;

        case (state)
            IDLE: begin
                if (bus.iSTART) begin
                    win_x_next   = '0;
                    win_y_next   = '0;
                    hit_cnt_next = '0;
                    hit_x_next   = '0;
                    hit_y_next   = '0;
                    timeout_next = 1'b0;
                    state_next   = ARM;
                end
            end

            ARM: begin
                if (bus.iFRAME_END) begin
                    state_next = MEASURE;
                end
            end

            MEASURE: begin
                if (bus.iFRAME_END) begin
                    to_cnt_next = '0;
                    state_next  = RESULT;
                end
            end

            RESULT: begin
                // A strobe on the terminal-count cycle still counts as a
                // verdict, so it is tested before the timeout.
                if (bus.iRESULT_VALID) begin
                    if (bus.iRESULT) begin
                        hit_cnt_next = (hit_cnt == 8'hFF) ? 8'hFF : hit_cnt + 8'd1;
                        hit_x_next   = win_x;
                        hit_y_next   = win_y;
                    end
                    state_next = ADVANCE;
                end else if (to_cnt == TMAX) begin
                    timeout_next = 1'b1;
                    state_next   = ADVANCE;
                end else begin
                    to_cnt_next = to_cnt + CW'(1);
                end
            end

            ADVANCE: begin
                if (x_fits) begin
                    win_x_next = x_step[12:0];
                    state_next = ARM;
                end else begin
                    win_x_next = '0;
                    if (y_fits) begin
                        win_y_next = y_step[12:0];
                        state_next = ARM;
                    end else begin
                        // Last window of the grid.
                        scan_done_next = 1'b1;
                        if (bus.iCONTINUOUS) begin
                            win_y_next   = '0;
                            hit_cnt_next = '0;
                            hit_x_next   = '0;
                            hit_y_next   = '0;
                            timeout_next = 1'b0;
                            state_next   = ARM;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Busy covers the done-pulse cycle even when returning to IDLE.
        busy_next = (state_next != IDLE) || scan_done_next;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state        <= IDLE;
            win_x        <= '0;
            win_y        <= '0;
            hit_cnt      <= '0;
            hit_x        <= '0;
            hit_y        <= '0;
            timeout_flag <= 1'b0;
            busy         <= 1'b0;
            scan_done    <= 1'b0;
            is_bound     <= 1'b0;
            to_cnt       <= '0;
        end else begin
            state        <= state_next;
            win_x        <= win_x_next;
            win_y        <= win_y_next;
            hit_cnt      <= hit_cnt_next;
            hit_x        <= hit_x_next;
            hit_y        <= hit_y_next;
            timeout_flag <= timeout_next;
            busy         <= busy_next;
            scan_done    <= scan_done_next;
            is_bound     <= is_bound_next;
            to_cnt       <= to_cnt_next;
        end
    end

    assign bus.oWIN_X     = win_x;
    assign bus.oWIN_Y     = win_y;
    assign bus.oIS_BOUND  = is_bound;
    assign bus.oBUSY      = busy;
    assign bus.oSCAN_DONE = scan_done;
    assign bus.oHIT_COUNT = hit_cnt;
    assign bus.oHIT_X     = hit_x;
    assign bus.oHIT_Y     = hit_y;
    assign bus.oTIMEOUT   = timeout_flag;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_window_scan_scheduler.sv
// ----------------------------------------------------------------------------
// tb_window_scan_scheduler
//
// Purpose: self-checking bench for window_scan_scheduler at default
// parameters. Frame ends are generated as short synthetic pulses so a full
// 266-window scan stays short. Inputs change on the falling edge; outputs are
// checked on the falling edge.
// ----------------------------------------------------------------------------
module tb_window_scan_scheduler;

    localparam int FRAME_W = 640;
    localparam int FRAME_H = 480;
    localparam int WIN_W   = 64;
    localparam int WIN_H   = 64;
    localparam int STEP    = 32;
    localparam int TIMEOUT = 1024;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_RESULT  = 3'd3;
    localparam logic [2:0] S_ADVANCE = 3'd4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic iCLK   = 1'b0;
    logic iRST_N = 1'b0;

    always #5 iCLK = ~iCLK;

    window_scan_scheduler_if bus();

    window_scan_scheduler #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .WIN_W   (WIN_W),
        .WIN_H   (WIN_H),
        .STEP    (STEP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    int          done_cnt = 0;
    logic [25:0] exp_q[$];       // expected window origins {x, y}
    int          exp_hits;
    logic [12:0] exp_hx;
    logic [12:0] exp_hy;
    logic        exp_to;

    typedef struct {
        logic [12:0] x;
        logic [12:0] y;
        logic        bound;
    } bound_vec_t;

    bound_vec_t bvec[11];

    always @(negedge iCLK) begin
        if (bus.oSCAN_DONE === 1'b1) done_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Checker and driver tasks
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic pulse_start();
        bus.iSTART = 1'b1;
        cyc(1);
        bus.iSTART = 1'b0;
    endtask

    task automatic pulse_frame_end();
        bus.iFRAME_END = 1'b1;
        cyc(1);
        bus.iFRAME_END = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},   bus.dbg_state,  S_IDLE);
        check({tag, "_win_x"},   bus.oWIN_X,     0);
        check({tag, "_win_y"},   bus.oWIN_Y,     0);
        check({tag, "_bound"},   bus.oIS_BOUND,  0);
        check({tag, "_busy"},    bus.oBUSY,      0);
        check({tag, "_done"},    bus.oSCAN_DONE, 0);
        check({tag, "_hits"},    bus.oHIT_COUNT, 0);
        check({tag, "_hit_x"},   bus.oHIT_X,     0);
        check({tag, "_hit_y"},   bus.oHIT_Y,     0);
        check({tag, "_timeout"}, bus.oTIMEOUT,   0);
    endtask

    // Independent model of the window grid in scan order.
    task automatic fill_grid();
        exp_q.delete();
        for (int y = 0; y + WIN_H <= FRAME_H; y += STEP)
            for (int x = 0; x + WIN_W <= FRAME_W; x += STEP)
                exp_q.push_back({13'(x), 13'(y)});
    endtask

    task automatic clear_model();
        exp_hits = 0;
        exp_hx   = '0;
        exp_hy   = '0;
        exp_to   = 1'b0;
    endtask

    // Runs one window starting from an ARM cycle. d = verdict delay in cycles
    // after the MEASURE frame end (d = 0 withholds the verdict). Returns on
    // the cycle after ADVANCE.
    task automatic run_window(input logic res, input int d);
        logic [25:0] org;
        org = exp_q.pop_front();
        check("state_arm", bus.dbg_state, S_ARM);
        check("win_x", bus.oWIN_X, org[25:13]);
        check("win_y", bus.oWIN_Y, org[12:0]);
        pulse_frame_end();
        check("state_measure", bus.dbg_state, S_MEASURE);
        cyc(2);
        pulse_frame_end();
        check("state_result", bus.dbg_state, S_RESULT);
        if (d == 0) begin
            cyc(TIMEOUT - 1);
            check("timeout_before_tc", bus.oTIMEOUT, exp_to);
            cyc(1);
            exp_to = 1'b1;
        end else begin
            if (d > 1) cyc(d - 1);
            bus.iRESULT_VALID = 1'b1;
            bus.iRESULT       = res;
            cyc(1);
            bus.iRESULT_VALID = 1'b0;
            bus.iRESULT       = 1'b0;
            if (res) begin
                exp_hits = (exp_hits == 255) ? 255 : exp_hits + 1;
                exp_hx   = org[25:13];
                exp_hy   = org[12:0];
            end
        end
        check("state_advance", bus.dbg_state, S_ADVANCE);
        check("win_x_hold", bus.oWIN_X, org[25:13]);
        check("win_y_hold", bus.oWIN_Y, org[12:0]);
        check("hit_count", bus.oHIT_COUNT, exp_hits);
        check("hit_x", bus.oHIT_X, exp_hx);
        check("hit_y", bus.oHIT_Y, exp_hy);
        check("timeout", bus.oTIMEOUT, exp_to);
        cyc(1);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int          done_base;
        int          widx;
        logic [25:0] nxt;
        logic        res;

        // Perimeter vectors for origin (32,0): box spans x 32..95, y 0..63.
        bvec[0]  = '{13'd32, 13'd10, 1'b1};
        bvec[1]  = '{13'd95, 13'd10, 1'b1};
        bvec[2]  = '{13'd50, 13'd0,  1'b1};
        bvec[3]  = '{13'd50, 13'd63, 1'b1};
        bvec[4]  = '{13'd96, 13'd10, 1'b0};
        bvec[5]  = '{13'd50, 13'd64, 1'b0};
        bvec[6]  = '{13'd31, 13'd0,  1'b0};
        bvec[7]  = '{13'd32, 13'd0,  1'b1};
        bvec[8]  = '{13'd95, 13'd63, 1'b1};
        bvec[9]  = '{13'd60, 13'd30, 1'b0};
        bvec[10] = '{13'd32, 13'd64, 1'b0};

        bus.iSTART        = 1'b0;
        bus.iCONTINUOUS   = 1'b0;
        bus.iX_POS        = '0;
        bus.iY_POS        = '0;
        bus.iFRAME_END    = 1'b0;
        bus.iRESULT_VALID = 1'b0;
        bus.iRESULT       = 1'b0;
        clear_model();

        // Power-on reset; pixel (0,0) lies on the (0,0) box but IDLE masks it.
        iRST_N = 1'b0;
        cyc(3);
        iRST_N = 1'b1;
        cyc(2);
        check_all_zero("por");

        // Reset in the middle of MEASURE.
        pulse_start();
        check("rst_test_arm", bus.dbg_state, S_ARM);
        pulse_frame_end();
        check("rst_test_measure", bus.dbg_state, S_MEASURE);
        check("rst_test_busy", bus.oBUSY, 1);
        iRST_N = 1'b0;
        cyc(3);
        check_all_zero("mid_rst");
        iRST_N = 1'b1;
        cyc(1);
        check("idle_after_rst", bus.dbg_state, S_IDLE);
        pulse_start();
        check("start_to_arm", bus.dbg_state, S_ARM);
        check("start_busy", bus.oBUSY, 1);

        // Scan A: grid walk, every verdict is a miss.
        fill_grid();
        clear_model();
        done_base = done_cnt;
        widx = 0;
        while (exp_q.size() > 0) begin
            if (exp_q.size() == 1) check("no_early_done", done_cnt, done_base);
            run_window(1'b0, 5);
            widx++;
        end
        check("scan_a_windows", widx, 266);
        check("scan_a_done", bus.oSCAN_DONE, 1);
        check("scan_a_busy_on_done", bus.oBUSY, 1);
        check("scan_a_idle", bus.dbg_state, S_IDLE);
        check("scan_a_end_x", bus.oWIN_X, 0);
        check("scan_a_end_y", bus.oWIN_Y, 416);
        check("scan_a_hits", bus.oHIT_COUNT, 0);
        cyc(1);
        check("scan_a_done_low", bus.oSCAN_DONE, 0);
        check("scan_a_busy_low", bus.oBUSY, 0);
        cyc(1);
        check("scan_a_one_done", done_cnt, done_base + 1);

        // Verdict outside RESULT is ignored while idle.
        bus.iRESULT_VALID = 1'b1;
        bus.iRESULT       = 1'b1;
        cyc(1);
        bus.iRESULT_VALID = 1'b0;
        bus.iRESULT       = 1'b0;
        cyc(1);
        check("idle_strobe_ignored", bus.oHIT_COUNT, 0);

        // Scan B: terminal-count verdict, timeout, perimeter and two hits.
        pulse_start();
        fill_grid();
        clear_model();
        done_base = done_cnt;
        while (exp_q.size() > 0) begin
            nxt = exp_q[0];
            res = (nxt == {13'd64, 13'd32}) || (nxt == {13'd128, 13'd96});
            if (nxt == {13'd0, 13'd0}) begin
                run_window(1'b0, TIMEOUT);
            end else if (nxt == {13'd32, 13'd0}) begin
                for (int i = 0; i < 11; i++) begin
                    bus.iX_POS = bvec[i].x;
                    bus.iY_POS = bvec[i].y;
                    cyc(1);
                    check($sformatf("bound_%0d_%0d", bvec[i].x, bvec[i].y),
                          bus.oIS_BOUND, bvec[i].bound);
                end
                bus.iX_POS = '0;
                bus.iY_POS = '0;
                // Frame end and strobe ignored here; ARM keeps waiting.
                bus.iRESULT_VALID = 1'b1;
                cyc(1);
                bus.iRESULT_VALID = 1'b0;
                check("arm_strobe_ignored", bus.dbg_state, S_ARM);
                run_window(1'b0, 0);
                check("after_timeout_x", bus.oWIN_X, 64);
                check("after_timeout_y", bus.oWIN_Y, 0);
            end else begin
                run_window(res, 5);
            end
        end
        check("scan_b_done", bus.oSCAN_DONE, 1);
        check("scan_b_hits", bus.oHIT_COUNT, 2);
        check("scan_b_hit_x", bus.oHIT_X, 128);
        check("scan_b_hit_y", bus.oHIT_Y, 96);
        check("scan_b_timeout", bus.oTIMEOUT, 1);
        cyc(2);
        check("scan_b_one_done", done_cnt, done_base + 1);

        // Scan C: continuous mode, hit on every window, stray starts.
        bus.iCONTINUOUS = 1'b1;
        pulse_start();
        check("scan_c_start_clears_to", bus.oTIMEOUT, 0);
        fill_grid();
        clear_model();
        widx = 0;
        while (exp_q.size() > 0) begin
            if (widx == 10 || widx == 100) pulse_start();
            run_window(1'b1, 3);
            widx++;
            if (widx == 260) check("saturated", bus.oHIT_COUNT, 255);
        end
        check("cont_done", bus.oSCAN_DONE, 1);
        check("cont_busy", bus.oBUSY, 1);
        check("cont_state", bus.dbg_state, S_ARM);
        check("cont_x", bus.oWIN_X, 0);
        check("cont_y", bus.oWIN_Y, 0);
        check("cont_hits_clr", bus.oHIT_COUNT, 0);
        check("cont_hit_x_clr", bus.oHIT_X, 0);
        check("cont_hit_y_clr", bus.oHIT_Y, 0);
        cyc(1);
        check("cont_done_low", bus.oSCAN_DONE, 0);
        check("cont_busy_hold", bus.oBUSY, 1);
        fill_grid();
        clear_model();
        run_window(1'b1, 2);

        // Reset from mid-scan ends the run.
        bus.iCONTINUOUS = 1'b0;
        iRST_N = 1'b0;
        cyc(2);
        iRST_N = 1'b1;
        check_all_zero("final_rst");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
